fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h0000_0000_8000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port ireq_valid, output, 1: instruction-bus request valid.
REQ-005 SHALL have port ireq_addr, output, 64: instruction-bus request address.
REQ-006 SHALL have port iresp_addr_ok, input, 1: bus accepts the request address this cycle.
REQ-007 SHALL have port iresp_data_ok, input, 1: bus returns instruction data this cycle.
REQ-008 SHALL have port iresp_data, input, 32: returned instruction word.
REQ-009 SHALL have port stall, input, 1: decode cannot take the presented instruction this cycle.
REQ-010 SHALL have port redirect_valid, input, 1: branch/jump resolved, fetch path flushed.
REQ-011 SHALL have port redirect_pc, input, 64: new fetch target.
REQ-012 SHALL have port out_valid, output, 1: the instruction presented to decode is valid.
REQ-013 SHALL have port out_pc, output, 64: PC of the presented instruction.
REQ-014 SHALL have port out_raw_instr, output, 32: raw instruction word fed to the decoder.

Function
REQ-015 SHALL keep one request outstanding at most, using states S_REQ, S_WAIT and S_HOLD, plus registers pc, inflight_pc, skid_instr and skid_pc, and a discard flag.
REQ-016 In S_REQ it SHALL drive ireq_valid=1 and ireq_addr=pc.
REQ-017 In S_REQ, on addr_ok it SHALL set inflight_pc<=pc and pc<=pc+4 (64-bit, wrapping), then go to S_WAIT.
REQ-018 In S_WAIT and S_HOLD it SHALL drive ireq_valid=0.
REQ-019 out_valid, out_pc and out_raw_instr SHALL be registered: out_valid is a one-entry output buffer.
- The buffer is consumed at an edge where out_valid=1 and stall=0.
REQ-020 In S_WAIT, on data_ok with discard=0:
- if the buffer is empty or being consumed, it SHALL load the buffer with {1, inflight_pc, iresp_data} and go to S_REQ;
- otherwise it SHALL load skid_{instr,pc} and go to S_HOLD.
REQ-021 In S_WAIT, on data_ok with discard=1, it SHALL drop the data, clear discard and go to S_REQ.
REQ-022 In S_HOLD, when the buffer is consumed, it SHALL move the skid contents into the buffer at that edge and go to S_REQ.
REQ-023 If the buffer is consumed with no new load, it SHALL set out_valid<=0; out_pc and out_raw_instr hold their values.
REQ-024 redirect_valid SHALL have priority over every other event, and at that edge it SHALL:
- set out_valid<=0;
- set pc<={redirect_pc[63:2],2'b00};
- go to S_REQ;
- drop any skid contents.
REQ-025 On redirect, it SHALL set discard<=1 if a request is in flight after the edge: in S_WAIT without data_ok, or in S_REQ with addr_ok.
REQ-026 Redirect in S_WAIT with data_ok SHALL drop the data and leave discard=0.
REQ-027 data_ok in S_REQ or S_HOLD SHALL be ignored; addr_ok outside S_REQ SHALL be ignored.
REQ-028 The stall input SHALL never modify pc or bus state directly: it only blocks consumption of the buffer.
REQ-029 Back-to-back throughput SHALL be one instruction per 2 cycles when addr_ok and data_ok each arrive in the first cycle offered, with stall=0.

Reset
REQ-030 While reset=0 at an edge, it SHALL set:
- state=S_REQ, pc=PC_RESET, discard=0;
- out_valid=0, out_pc=0, out_raw_instr=0;
- inflight_pc=0, skid_pc=0, skid_instr=0.
REQ-031 ireq_valid SHALL be 0 in any cycle where reset=0, including mid-transaction.
REQ-032 After reset deasserts, the first request SHALL issue in the first cycle with ireq_valid=1, ireq_addr=PC_RESET.

Verification
REQ-033 Basic fetch: addr_ok in the cycle after reset release, data_ok=1 with data=32'h00000013 on the next cycle -> out_valid=1, out_pc=0x80000000, out_raw_instr=0x00000013; the next ireq_addr is 0x80000004.
REQ-034 Stall/skid: stall=1 held with the buffer full, then a second data_ok (0x00100093) -> state S_HOLD, ireq_valid=0; on stall release the first is consumed, the buffer shows pc 0x80000004 / 0x00100093, and the fetch of 0x80000008 follows.
REQ-035 Redirect in flight: in S_WAIT, redirect_valid to 0x80001002 -> out_valid=0, the later data_ok is dropped, and the next ireq_addr is 0x80001000.
REQ-036 Simultaneous events: redirect_valid with data_ok in S_WAIT -> no instruction delivered, discard stays 0, ireq_valid=1 with addr redirect_pc the next cycle; redirect with addr_ok in S_REQ -> the next data_ok is dropped.
REQ-037 Reset mid-operation: reset=0 during S_HOLD -> out_valid=0, ireq_valid=0; after release ireq_addr=0x80000000.
REQ-038 Wrap: redirect to 0xFFFFFFFFFFFFFFFC, addr_ok -> pc becomes 0, and the instruction is delivered with out_pc=0xFFFFFFFFFFFFFFFC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps at most one bus request in flight, holds the
// fetched word in a one-entry output buffer backed by a one-entry skid slot.
module fetch_stage #(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_raw_instr
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_reg, state_next;
   logic [63:0] pc_reg, pc_next;
   logic [63:0] inflight_pc_reg, inflight_pc_next;
   logic [63:0] skid_pc_reg, skid_pc_next;
   logic [31:0] skid_instr_reg, skid_instr_next;
   logic        discard_reg, discard_next;
   logic        out_valid_reg, out_valid_next;
   logic [63:0] out_pc_reg, out_pc_next;
   logic [31:0] out_instr_reg, out_instr_next;
   logic        consume;

   assign ireq_valid    = reset && (state_reg == S_REQ);
   assign ireq_addr     = pc_reg;
   assign out_valid     = out_valid_reg;
   assign out_pc        = out_pc_reg;
   assign out_raw_instr = out_instr_reg;

   always_comb begin
      consume          = out_valid_reg && !stall;
      state_next       = state_reg;
      pc_next          = pc_reg;
      inflight_pc_next = inflight_pc_reg;
      skid_pc_next     = skid_pc_reg;
      skid_instr_next  = skid_instr_reg;
      discard_next     = discard_reg;
      out_valid_next   = out_valid_reg;
      out_pc_next      = out_pc_reg;
      out_instr_next   = out_instr_reg;

      if (consume)
         out_valid_next = 1'b0;

      if (redirect_valid) begin
         // Any request still outstanding after this edge must have its data thrown away.
         out_valid_next = 1'b0;
         pc_next        = {redirect_pc[63:2], 2'b00};
         state_next     = S_REQ;
         if (((state_reg == S_WAIT) && !iresp_data_ok) || ((state_reg == S_REQ) && iresp_addr_ok))
            discard_next = 1'b1;
         else if ((state_reg == S_WAIT) && iresp_data_ok)
            discard_next = 1'b0;
      end else begin
         unique case (state_reg)
            S_REQ: begin
               if (iresp_addr_ok) begin
                  inflight_pc_next = pc_reg;
                  pc_next          = pc_reg + 64'd4;
                  state_next       = S_WAIT;
               end
            end
            S_WAIT: begin
               if (iresp_data_ok) begin
                  if (discard_reg) begin
                     discard_next = 1'b0;
                     state_next   = S_REQ;
                  end else if (!out_valid_reg || consume) begin
                     out_valid_next = 1'b1;
                     out_pc_next    = inflight_pc_reg;
                     out_instr_next = iresp_data;
                     state_next     = S_REQ;
                  end else begin
                     skid_pc_next    = inflight_pc_reg;
                     skid_instr_next = iresp_data;
                     state_next      = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (consume) begin
                  out_valid_next = 1'b1;
                  out_pc_next    = skid_pc_reg;
                  out_instr_next = skid_instr_reg;
                  state_next     = S_REQ;
               end
            end
            default: state_next = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= S_REQ;
         pc_reg          <= PC_RESET;
         inflight_pc_reg <= 64'd0;
         skid_pc_reg     <= 64'd0;
         skid_instr_reg  <= 32'd0;
         discard_reg     <= 1'b0;
         out_valid_reg   <= 1'b0;
         out_pc_reg      <= 64'd0;
         out_instr_reg   <= 32'd0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         inflight_pc_reg <= inflight_pc_next;
         skid_pc_reg     <= skid_pc_next;
         skid_instr_reg  <= skid_instr_next;
         discard_reg     <= discard_next;
         out_valid_reg   <= out_valid_next;
         out_pc_reg      <= out_pc_next;
         out_instr_reg   <= out_instr_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, all checked
// against a queue-based model of the fetched-instruction stream.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_raw_instr;

   int checks = 0;
   int failures = 0;

   fetch_stage #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_pc(out_pc), .out_raw_instr(out_raw_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: q holds instructions fetched but not yet taken by decode (front is shown).
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [63:0] m_pc;
   logic [63:0] m_inflight;
   logic        m_waiting;
   logic        m_discard;
   logic [63:0] m_shown_pc;
   logic [31:0] m_shown_instr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc          = 64'h0000_0000_8000_0000;
      m_inflight    = 64'd0;
      m_waiting     = 1'b0;
      m_discard     = 1'b0;
      m_shown_pc    = 64'd0;
      m_shown_instr = 32'd0;
   endtask

   task automatic model_step();
      bit can_req;
      bit in_flight;
      can_req = !m_waiting && (m_q.size() < 2);
      if (!reset) begin
         model_reset();
      end else if (redirect_valid) begin
         in_flight = (m_waiting && !iresp_data_ok) || (can_req && iresp_addr_ok);
         if (in_flight)
            m_discard = 1'b1;
         else if (m_waiting && iresp_data_ok)
            m_discard = 1'b0;
         m_q.delete();
         m_waiting = 1'b0;
         m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
         if (m_q.size() > 0 && !stall)
            void'(m_q.pop_front());
         if (can_req && iresp_addr_ok) begin
            m_inflight = m_pc;
            m_pc       = m_pc + 64'd4;
            m_waiting  = 1'b1;
         end else if (m_waiting && iresp_data_ok) begin
            m_waiting = 1'b0;
            if (m_discard) begin
               m_discard = 1'b0;
            end else begin
               m_q.push_back('{pc: m_inflight, instr: iresp_data});
               $display("fetched pc=%h instr=%h", m_inflight, iresp_data);
            end
         end
      end
      if (m_q.size() > 0) begin
         m_shown_pc    = m_q[0].pc;
         m_shown_instr = m_q[0].instr;
      end
   endtask

   // One clock: drive at negedge, compare against model, then advance model at posedge.
   task automatic cycle(input logic rst, input logic aok, input logic dok, input logic [31:0] dat,
                        input logic stl, input logic rv, input logic [63:0] rpc);
      logic exp_iv;
      @(negedge clk);
      reset          = rst;
      iresp_addr_ok  = aok;
      iresp_data_ok  = dok;
      iresp_data     = dat;
      stall          = stl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      exp_iv = rst && !m_waiting && (m_q.size() < 2);
      check("ireq_valid", ireq_valid, exp_iv);
      if (exp_iv)
         check("ireq_addr", ireq_addr, m_pc);
      check("out_valid", out_valid, m_q.size() > 0);
      check("out_pc", out_pc, m_shown_pc);
      check("out_raw_instr", out_raw_instr, m_shown_instr);
      @(posedge clk);
      model_step();
   endtask

   initial begin
      reset = 1'b0; iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'd0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
      repeat (2) @(posedge clk);
      model_reset();
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_pc", out_pc, 64'd0);

      // Basic fetch
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
      #1;
      check("basic_valid", out_valid, 1'b1);
      check("basic_pc", out_pc, 64'h8000_0000);
      check("basic_instr", out_raw_instr, 32'h0000_0013);
      check("basic_next_addr", ireq_addr, 64'h8000_0004);

      // Stall with buffer full goes through the skid slot
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 64'd0);
      #1;
      check("hold_ireq_valid", ireq_valid, 1'b0);
      check("hold_out_pc", out_pc, 64'h8000_0000);
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      #1;
      check("skid_pc", out_pc, 64'h8000_0004);
      check("skid_instr", out_raw_instr, 32'h0010_0093);
      check("skid_next_addr", ireq_addr, 64'h8000_0008);
      check("skid_ireq_valid", ireq_valid, 1'b1);

      // Redirect while waiting: the following response is dropped
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_1002);
      #1;
      check("redir_out_valid", out_valid, 1'b0);
      check("redir_addr", ireq_addr, 64'h8000_1000);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'd0);
      #1;
      check("redir_dropped", out_valid, 1'b0);

      // Redirect together with data_ok, then together with addr_ok
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 64'h8000_2000);
      #1;
      check("sim_data_out_valid", out_valid, 1'b0);
      check("sim_data_ireq_valid", ireq_valid, 1'b1);
      check("sim_data_addr", ireq_addr, 64'h8000_2000);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_3000);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 64'd0);
      #1;
      check("sim_addr_dropped", out_valid, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
      #1;
      check("after_drop_pc", out_pc, 64'h8000_3004);
      check("after_drop_instr", out_raw_instr, 32'hDEAD_BEEF);

      // Reset while holding
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 64'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_ireq_valid", ireq_valid, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      #1;
      check("midrst_addr", ireq_addr, 64'h8000_0000);

      // Address wrap
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 64'd0);
      #1;
      check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_next_addr", ireq_addr, 64'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [63:0] rpc;
         rpc = {$urandom, $urandom};
         cycle($urandom_range(99, 0) >= 2,
               $urandom_range(1, 0) == 1,
               $urandom_range(1, 0) == 1,
               $urandom,
               $urandom_range(9, 0) < 4,
               $urandom_range(99, 0) < 4,
               rpc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
